pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised WIDTH-bit add/subtract unit that splits the ripple-carry chain into STAGES
//  registered slices, with carry-in, carry/borrow-out and signed overflow flag.
//  Uses valid/ready handshakes on input and output. Back-pressure stalls the pipeline, and
//  bubbles are collapsed. Sits between operand producers and result consumers in datapaths
//  that need more than a 4-bit combinational adder at full clock rate.
// PARAMETERS
//  WIDTH   8   operand width in bits; must be >= 1 and divisible by STAGES
//  STAGES  4   pipeline depth = number of carry slices, each SLICE = WIDTH/STAGES bits; >= 1
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        unit can accept operand beat this cycle
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B
//  cin        in   1        carry-in (add) / borrow-in (sub)
//  sub        in   1        0: add, 1: subtract
//  out_valid  out  1        result beat valid
//  out_ready  in   1        consumer accepts result this cycle
//  sum        out  WIDTH+1  {carry_out, result}; when sub=1, sum[WIDTH]=1 means no borrow
//  ovf        out  1        signed two's-complement overflow of result[WIDTH-1:0]
// BEHAVIOUR
//  - Arithmetic: result = a + (b ^ {WIDTH{sub}}) + (cin ^ sub), evaluated mod 2^(WIDTH+1).
//    This gives a+b+cin for add and a-b-cin for subtract.
//    ovf = (a[W-1] == b_eff[W-1]) && (result[W-1] != a[W-1]), where b_eff = b ^ {WIDTH{sub}}.
//  - Slicing: stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] using the carry registered by
//    stage k-1. Stage 0 uses cin^sub as its carry.
//    Upper unprocessed operand bits and lower finished result bits travel with the beat in
//    stage registers. No combinational path spans more than one slice.
//  - Latency: exactly STAGES cycles from input handshake (in_valid&in_ready) to out_valid,
//    when no stall occurs. Throughput is 1 beat/cycle when out_ready is held high.
//  - Handshake: a beat transfers on a cycle where valid&ready are both 1.
//    Producer holds a/b/cin/sub stable while in_valid=1 and in_ready=0.
//    out_valid, sum and ovf stay stable while out_valid=1 and out_ready=0.
//    out_valid does not depend combinationally on out_ready.
//  - Flow control: each stage has a valid bit v[k]. adv[STAGES-1] = ~v[last] | out_ready.
//    adv[k] = ~v[k] | adv[k+1]. in_ready = adv[0].
//    Stage k loads from stage k-1 when adv[k]. It clears v[k] when adv[k] and the upstream
//    stage is not valid.
//    Bubbles collapse: an empty stage accepts data even while downstream stages are stalled.
//  - Output: out_valid = v[STAGES-1]; sum and ovf come directly from the last stage registers.
//  - Reset (rst_n low, async): all v[k]=0, out_valid=0, sum=0, ovf=0, all datapath registers
//    cleared. in_ready=1 one cycle after reset release.
//    Beats in flight when reset asserts are discarded; no partial result is ever presented.
//  - Simultaneous events: output drain and input accept in the same cycle on a full pipe are
//    legal and lossless.
//    in_valid held low while out_ready=0 keeps the stalled output stable.
//  - STAGES=1: degenerates to a single registered full-width adder with the same handshake.
//  - Wrap-around: carry out of the top bit goes only to sum[WIDTH]; result bits wrap mod 2^WIDTH.
// TESTING  (WIDTH=8, STAGES=4 unless noted)
//  1. Add a=8'hFF, b=8'h01, cin=0, sub=0, out_ready=1 -> after 4 cycles out_valid=1,
//     sum=9'h100, ovf=0.
//  2. Sub a=8'h05, b=8'h07, cin=0, sub=1 -> sum=9'h0FE (borrow, sum[8]=0), ovf=0.
//     Signed overflow case: add 8'h7F+8'h01 -> sum=9'h080, ovf=1.
//  3. Stream 16 back-to-back random beats with out_ready=1 -> in_ready stays 1 and results
//     match a golden model in order, one per cycle after 4-cycle fill.
//  4. Fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0 after 4 accepted beats,
//     and outputs stay stable. Release -> all beats are delivered in order, with none lost
//     or duplicated.
//  5. Insert bubbles (in_valid toggling) while out_ready=0 -> bubbles collapse.
//     The unit accepts exactly 4 beats before in_ready falls.
//  6. Assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0 and sum=0 immediately.
//     After release, no stale beat appears. Repeat at STAGES=1, WIDTH=4 and STAGES=8,
//     WIDTH=32 against the golden model.

Source files
------------

// File: rtl/pipelined_adder.sv
// Add/subtract unit whose carry chain is cut into STAGES registered slices.
// The stages use valid/ready flow control, and bubbles in the pipe collapse.
module pipelined_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             ovf
);

   localparam int SLICE = WIDTH / STAGES;
   localparam int BTOT  = STAGES * WIDTH - SLICE * STAGES * (STAGES - 1) / 2;

   logic [STAGES-1:0]            vAll;
   logic [STAGES-1:0]            adv;
   logic [STAGES-1:0]            vSrc;
   logic [STAGES-1:0]            cSrc;
   logic [STAGES-1:0][WIDTH-1:0] xSrc;
   logic [BTOT-1:0]              bSrc;

   assign xSrc[0]            = a;
   assign cSrc[0]            = cin ^ sub;
   assign vSrc[0]            = in_valid;
   assign bSrc[0 +: WIDTH]   = b ^ {WIDTH{sub}};

   // A stage may advance if it is empty or everything below it advances.
   always_comb begin
      logic advAcc;
      advAcc = ~vAll[STAGES-1] | out_ready;
      adv[STAGES-1] = advAcc;
      for (int k = STAGES - 2; k >= 0; k--) begin
         advAcc = ~vAll[k] | advAcc;
         adv[k] = advAcc;
      end
   end

   assign in_ready = adv[0];

   // The x word holds finished result slices at the top and the unprocessed bits of a
   // below them, so it shifts down by one slice per stage. Unused b bits shrink per stage.
   for (genvar k = 0; k < STAGES; k++) begin : gStage
      localparam int BW   = WIDTH - k * SLICE;
      localparam int BOFF = k * WIDTH - SLICE * k * (k - 1) / 2;

      logic [BW-1:0]  bIn;
      logic [SLICE:0] sliceSum;
      logic           vQ;

      assign bIn      = bSrc[BOFF +: BW];
      assign sliceSum = {1'b0, xSrc[k][SLICE-1:0]} + {1'b0, bIn[SLICE-1:0]}
                      + {{SLICE{1'b0}}, cSrc[k]};
      assign vAll[k]  = vQ;

      if (k < STAGES - 1) begin : gMid
         logic [WIDTH-1:0]    xQ;
         logic [BW-SLICE-1:0] bQ;
         logic                cQ;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vQ <= 1'b0;
               xQ <= '0;
               bQ <= '0;
               cQ <= 1'b0;
            end else if (adv[k]) begin
               vQ <= vSrc[k];
               if (vSrc[k]) begin
                  xQ <= {sliceSum[SLICE-1:0], xSrc[k][WIDTH-1:SLICE]};
                  bQ <= bIn[BW-1:SLICE];
                  cQ <= sliceSum[SLICE];
               end
            end
         end

         assign xSrc[k+1]                  = xQ;
         assign cSrc[k+1]                  = cQ;
         assign vSrc[k+1]                  = vQ;
         assign bSrc[BOFF+BW +: BW-SLICE]  = bQ;
      end else begin : gLast
         logic [WIDTH-1:0] resD;
         logic [WIDTH:0]   sumQ;
         logic             ovfQ;

         always_comb begin
            resD = xSrc[k] >> SLICE;
            resD[WIDTH-1 -: SLICE] = sliceSum[SLICE-1:0];
         end

         // The top slice of a and b_eff sits in the low bits here, so the sign bits are at SLICE-1.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vQ   <= 1'b0;
               sumQ <= '0;
               ovfQ <= 1'b0;
            end else if (adv[k]) begin
               vQ <= vSrc[k];
               if (vSrc[k]) begin
                  sumQ <= {sliceSum[SLICE], resD};
                  ovfQ <= (xSrc[k][SLICE-1] == bIn[SLICE-1]) &&
                          (resD[WIDTH-1] != xSrc[k][SLICE-1]);
               end
            end
         end

         assign out_valid = vQ;
         assign sum       = sumQ;
         assign ovf       = ovfQ;
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three configurations share one stimulus driver and a
// scoreboard fed by an independent arithmetic model.
module tb_pipelined_adder;

   typedef struct packed {
      logic [32:0] sum;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] aDrv, bDrv;
   logic        cinDrv, subDrv, inValid, outReady;
   int          sel, w, stg;

   logic        rdy0, val0, ovf0;
   logic [8:0]  sum0;
   logic        rdy1, val1, ovf1;
   logic [4:0]  sum1;
   logic        rdy2, val2, ovf2;
   logic [32:0] sum2;

   logic        obsReady, obsValid, obsOvf;
   logic [32:0] obsSum;

   int          checks = 0;
   int          errors = 0;
   int          stallCount = 0;
   int          seen = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(8), .STAGES(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 0), .in_ready(rdy0),
      .a(aDrv[7:0]), .b(bDrv[7:0]), .cin(cinDrv), .sub(subDrv),
      .out_valid(val0), .out_ready(outReady), .sum(sum0), .ovf(ovf0));

   pipelined_adder #(.WIDTH(4), .STAGES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 1), .in_ready(rdy1),
      .a(aDrv[3:0]), .b(bDrv[3:0]), .cin(cinDrv), .sub(subDrv),
      .out_valid(val1), .out_ready(outReady), .sum(sum1), .ovf(ovf1));

   pipelined_adder #(.WIDTH(32), .STAGES(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 2), .in_ready(rdy2),
      .a(aDrv), .b(bDrv), .cin(cinDrv), .sub(subDrv),
      .out_valid(val2), .out_ready(outReady), .sum(sum2), .ovf(ovf2));

   always_comb begin
      obsReady = rdy2;
      obsValid = val2;
      obsOvf   = ovf2;
      obsSum   = sum2;
      case (sel)
         0: begin obsReady = rdy0; obsValid = val0; obsOvf = ovf0; obsSum = {24'b0, sum0}; end
         1: begin obsReady = rdy1; obsValid = val1; obsOvf = ovf1; obsSum = {28'b0, sum1}; end
         default: ;
      endcase
   end

   function automatic logic [31:0] maskOf(int width);
      return (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
   endfunction

   function automatic exp_t model(logic [31:0] av, logic [31:0] bv, logic c, logic s, int width);
      logic [31:0] mask, bEff, aM, res;
      logic [33:0] full;
      exp_t        e;
      mask   = maskOf(width);
      aM     = av & mask;
      bEff   = (bv ^ {32{s}}) & mask;
      full   = {2'b0, aM} + {2'b0, bEff} + {33'b0, c ^ s};
      res    = full[31:0] & mask;
      e.sum  = {1'b0, res} | ({32'b0, full[width]} << width);
      e.ovf  = (aM[width-1] == bEff[width-1]) && (res[width-1] != aM[width-1]);
      return e;
   endfunction

   // Scoreboard monitor: sample away from the rising edge and record every handshake.
   logic        prevStall = 1'b0;
   logic [32:0] prevSum;
   logic        prevOvf;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checks++;
            assert (obsValid === 1'b1 && obsSum === prevSum && obsOvf === prevOvf) else begin
               errors++;
               $error("[TB] FAIL stall_stable observed=%b/%h/%b expected=1/%h/%b",
                      obsValid, obsSum, obsOvf, prevSum, prevOvf);
            end
         end
         if (obsValid && outReady) begin
            seen++;
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("[TB] FAIL stale_beat observed=%h expected=no_output", obsSum);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               checks++;
               assert ({obsSum, obsOvf} === {e.sum, e.ovf}) else begin
                  errors++;
                  $error("[TB] FAIL result observed=%h/%b expected=%h/%b",
                         obsSum, obsOvf, e.sum, e.ovf);
               end
            end
         end
         if (inValid && obsReady)
            sb.push_back(model(aDrv, bDrv, cinDrv, subDrv, w));
         prevStall = obsValid && !outReady;
         prevSum   = obsSum;
         prevOvf   = obsOvf;
      end
   end

   task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic idleCycles(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the beat was taken.
   task automatic applyStimulus(logic [31:0] av, logic [31:0] bv, logic c, logic s);
      int n = 0;
      aDrv    = av & maskOf(w);
      bDrv    = bv & maskOf(w);
      cinDrv  = c;
      subDrv  = s;
      inValid = 1'b1;
      @(negedge clk);
      if (!obsReady) stallCount++;
      while (!obsReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!obsReady) checkOutput("accept_timeout", {63'b0, obsReady}, 64'd1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   task automatic directed(string tag, logic [31:0] av, logic [31:0] bv, logic c, logic s,
                           logic [32:0] expSum, logic expOvf);
      int lat = 1;
      outReady = 1'b1;
      applyStimulus(av, bv, c, s);
      @(negedge clk);
      while (!obsValid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, stg);
      checkOutput({tag, "_sum"}, {31'b0, obsSum}, {31'b0, expSum});
      checkOutput({tag, "_ovf"}, {63'b0, obsOvf}, {63'b0, expOvf});
      @(posedge clk);
      #1;
   endtask

   task automatic stream(string tag, int n);
      outReady   = 1'b1;
      stallCount = 0;
      for (int i = 0; i < n; i++)
         applyStimulus($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idleCycles(stg + 3);
      checkOutput({tag, "_ready_held"}, stallCount, 0);
      checkOutput({tag, "_drained"}, sb.size(), 0);
   endtask

   task automatic stallFill(string tag, bit toggle);
      int accepted = 0;
      bit took;
      outReady = 1'b0;
      aDrv   = $urandom() & maskOf(w);
      bDrv   = $urandom() & maskOf(w);
      cinDrv = 1'($urandom_range(0, 1));
      subDrv = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 12; cyc++) begin
         inValid = toggle ? 1'(cyc % 2) : 1'b1;
         @(negedge clk);
         took = inValid && obsReady;
         if (took) accepted++;
         @(posedge clk);
         #1;
         if (took) begin
            aDrv   = $urandom() & maskOf(w);
            bDrv   = $urandom() & maskOf(w);
            cinDrv = 1'($urandom_range(0, 1));
            subDrv = 1'($urandom_range(0, 1));
         end
      end
      inValid = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_count"}, accepted, stg);
      checkOutput({tag, "_ready_low"}, {63'b0, obsReady}, 64'd0);
      @(posedge clk);
      #1;
      idleCycles(5);
      outReady = 1'b1;
      idleCycles(stg + 3);
      checkOutput({tag, "_drained"}, sb.size(), 0);
   endtask

   task automatic resetMid(string tag);
      int seenBefore;
      outReady = 1'b1;
      for (int i = 0; i < 3; i++)
         applyStimulus($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #2 rst_n = 1'b0;
      #1;
      checkOutput({tag, "_valid"}, {63'b0, obsValid}, 64'd0);
      checkOutput({tag, "_sum"}, {31'b0, obsSum}, 64'd0);
      sb.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      seenBefore = seen;
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_ready"}, {63'b0, obsReady}, 64'd1);
      @(posedge clk);
      #1;
      idleCycles(stg + 4);
      checkOutput({tag, "_no_stale"}, seen - seenBefore, 0);
   endtask

   task automatic setConfig(int s);
      sel = s;
      case (s)
         0: begin w = 8;  stg = 4; end
         1: begin w = 4;  stg = 1; end
         default: begin w = 32; stg = 8; end
      endcase
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      aDrv     = '0;
      bDrv     = '0;
      cinDrv   = 1'b0;
      subDrv   = 1'b0;
      setConfig(0);
      #12;
      checkOutput("reset_valid", {63'b0, obsValid}, 64'd0);
      checkOutput("reset_sum", {31'b0, obsSum}, 64'd0);
      checkOutput("reset_ovf", {63'b0, obsOvf}, 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_ready", {63'b0, obsReady}, 64'd1);
      @(posedge clk);
      #1;

      directed("add_carry", 32'hFF, 32'h01, 1'b0, 1'b0, 33'h100, 1'b0);
      directed("sub_borrow", 32'h05, 32'h07, 1'b0, 1'b1, 33'h0FE, 1'b0);
      directed("add_ovf", 32'h7F, 32'h01, 1'b0, 1'b0, 33'h080, 1'b1);
      directed("sub_cin", 32'h10, 32'h01, 1'b1, 1'b1, 33'h10E, 1'b0);
      stream("w8_stream", 16);
      stallFill("w8_stall", 1'b0);
      stallFill("w8_bubble", 1'b1);
      resetMid("w8_rst");
      stream("w8_after_rst", 6);

      setConfig(1);
      directed("w4_carry", 32'hF, 32'h1, 1'b0, 1'b0, 33'h10, 1'b0);
      stream("w4_stream", 16);
      resetMid("w4_rst");
      stream("w4_after_rst", 6);

      setConfig(2);
      directed("w32_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1);
      stream("w32_stream", 16);
      resetMid("w32_rst");
      stream("w32_after_rst", 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
